// File: rtl/seg7_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_arbiter
// Brief    : Round-robin time-sliced sharing of one 4-digit 7-seg display
// Revision : 1.0  initial release
// ============================================================================
module seg7_display_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int SLICE_CYCLES = 100_000_000,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*32-1:0]      pat,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic [3:0]                 an,
    output logic [7:0]                 seg
);
    localparam int c_OW = $clog2(NUM_REQ);
    localparam int c_SW = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
    localparam int c_RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int c_BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [c_SW-1:0] c_SLICE_LAST   = c_SW'(SLICE_CYCLES - 1);
    localparam logic [c_RW-1:0] c_REFRESH_LAST = c_RW'(REFRESH_DIV - 1);
    localparam logic [c_BW-1:0] c_BLANK_LAST   = c_BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [c_OW-1:0]     r_owner;
    logic                r_busy;
    logic [c_OW-1:0]     r_rr_ptr;
    logic [c_SW-1:0]     r_slice_cnt;
    logic [c_BW-1:0]     r_blank_cnt;
    logic [c_RW-1:0]     r_refresh_cnt;
    logic [1:0]          r_digit_sel;
    logic [3:0]          r_an;
    logic [7:0]          r_seg;

    logic                w_take;
    logic                w_drop;
    logic [c_OW-1:0]     w_winner;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic                w_owner_req;
    logic                w_others_req;
    logic                w_slice_end;
    logic                w_blank_end;
    logic [31:0]         w_pat_arr [NUM_REQ];
    logic [31:0]         w_pat_sel;
    logic [7:0]          w_seg_byte;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pat
        assign w_pat_arr[gi] = pat[gi*32 +: 32];
    end

    assign w_pat_sel    = w_pat_arr[r_owner];
    assign w_owner_req  = |(req & r_gnt);
    assign w_others_req = |(req & ~r_gnt);
    assign w_slice_end  = (r_slice_cnt == c_SLICE_LAST);
    assign w_blank_end  = (r_blank_cnt == c_BLANK_LAST);

    // Highest k assigned first so the nearest requester after rr_ptr wins.
    always_comb begin
        int              v_idx;
        logic [c_OW-1:0] v_sel;
        v_idx        = 0;
        v_sel        = '0;
        w_winner     = '0;
        w_win_onehot = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            v_sel = c_OW'(v_idx);
            if (req[v_sel]) begin
                w_winner = v_sel;
            end
        end
        w_win_onehot[w_winner] = 1'b1;
    end

    always_comb begin
        case (r_digit_sel)
            2'd0:    w_seg_byte = w_pat_sel[7:0];
            2'd1:    w_seg_byte = w_pat_sel[15:8];
            2'd2:    w_seg_byte = w_pat_sel[23:16];
            default: w_seg_byte = w_pat_sel[31:24];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_owner_req || (w_slice_end && w_others_req)) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                if (w_blank_end) begin
                    if (|req) begin
                        w_take      = 1'b1;
                        w_state_nxt = S_GRANT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt       <= '0;
            r_owner     <= '0;
            r_busy      <= 1'b0;
            r_rr_ptr    <= c_OW'(NUM_REQ - 1);
            r_slice_cnt <= '0;
            r_blank_cnt <= '0;
        end else if (w_take) begin
            r_gnt       <= w_win_onehot;
            r_owner     <= w_winner;
            r_busy      <= 1'b1;
            r_slice_cnt <= '0;
            r_rr_ptr    <= w_winner;
        end else if (w_drop) begin
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_blank_cnt <= '0;
        end else if (r_state == S_GRANT) begin
            r_slice_cnt <= w_slice_end ? '0 : r_slice_cnt + 1'b1;
        end else if (r_state == S_BLANK) begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
        end
    end

    // Scan timing free-runs in every state so the digit phase never jumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= 2'd0;
        end else if (r_refresh_cnt == c_REFRESH_LAST) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= r_digit_sel + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end else if (r_state == S_GRANT && w_state_nxt == S_GRANT) begin
            r_an  <= ~(4'b0001 << r_digit_sel);
            r_seg <= w_seg_byte;
        end else begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule
`default_nettype wire
